chan_mux_scan: RTL

Parametrised N-channel, W-bit registered multiplexer. It succeeds the fixed 8:1 single-bit combinational mux. It has two modes:
- Direct mode: a registered select path.
- Scan mode: a sequencer that sweeps the enabled channels once per start pulse, with a programmable dwell gap between channels.

The output uses a valid/ready handshake. The block sits between parallel data sources and a single serial consumer, such as a logger or serialiser.

---
 rtl/chan_mux_scan.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/chan_mux_scan.sv
// Registered N-channel mux with a direct select path and a one-shot scan
// sequencer that walks the enabled channels behind a valid/ready output.
module chan_mux_scan #(
    parameter int WIDTH   = 8,
    parameter int NUM_CH  = 8,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*WIDTH-1:0]   din,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic                      start,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, GAP} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_ch;
    logic               r_out_valid;
    logic [NUM_CH-1:0]  r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_xfer;
    logic               w_free;
    logic [WIDTH-1:0]   w_sel_data;
    logic [WIDTH-1:0]   w_ptr_data;
    logic [SEL_W-1:0]   w_first_ptr;
    logic [SEL_W-1:0]   w_next_ptr;
    logic               w_has_next;

    assign w_xfer = r_out_valid & out_ready;
    assign w_free = !r_out_valid | out_ready;

    // Select values outside the channel range fall through to zero data.
    always_comb begin
        w_sel_data = '0;
        w_ptr_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel) == i)
                w_sel_data = din[i*WIDTH +: WIDTH];
            if (int'(r_ptr) == i)
                w_ptr_data = din[i*WIDTH +: WIDTH];
        end
    end

    // Scanning downward lets the lowest qualifying index win.
    always_comb begin
        w_first_ptr = '0;
        w_next_ptr  = '0;
        w_has_next  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i])
                w_first_ptr = SEL_W'(i);
            if (r_mask[i] && (i > int'(r_ptr))) begin
                w_next_ptr = SEL_W'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_mask      <= '0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!mode) begin
                        if (w_free) begin
                            r_out_data  <= w_sel_data;
                            r_out_ch    <= sel;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        if (w_xfer)
                            r_out_valid <= 1'b0;
                        // A pending direct word must drain before the sweep begins.
                        if (start && (|ch_en) && w_free) begin
                            r_mask  <= ch_en;
                            r_dwell <= dwell;
                            r_ptr   <= w_first_ptr;
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    r_out_data  <= w_ptr_data;
                    r_out_ch    <= r_ptr;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        if (!w_has_next) begin
                            r_state <= IDLE;
                        end else begin
                            r_ptr <= w_next_ptr;
                            if (r_dwell == '0) begin
                                r_state <= LOAD;
                            end else begin
                                r_cnt   <= r_dwell;
                                r_state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= DWELL_W'(1))
                        r_state <= LOAD;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);

endmodule
